// File: rtl/mem_arb.sv
// mem_arb: shares one unified data memory between the I-cache fill path (read-only)
//   and the D-cache fill/writeback path (read/write), one transaction at a time.
// Latency: request seen in IDLE at cycle t -> mem_en at t+1, done at t+1+MEM_LAT,
//   back in IDLE at t+2+MEM_LAT.
// Backpressure: while busy, the other side is not acknowledged. Its level request
//   waits and is arbitrated at the next IDLE. D wins ties, except that after
//   MAX_STREAK D grants in a row with I waiting, I is served.
// Ports:
//   clk, rst (synchronous, active-low)
//   i_req/i_addr -> i_done/i_rdata                        I-side read
//   d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata           D-side read/write
//   mem_en/mem_wr/mem_addr/mem_wdata -> memory,  mem_rdata <- memory
//   busy                                                  arbiter not in IDLE
module mem_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 4,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  logic [1:0] state;
  logic [3:0] lat;
  logic [2:0] streak;
  logic       grantD;
  logic       grantI;

  // D wins unless I is waiting and D already had its full streak.
  always_comb begin
    grantD = d_req && (!i_req || (streak < STREAK_MAX));
    grantI = i_req && !grantD;
  end

  // busy comes straight from the state register, so it stays a registered output.
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lat       <= '0;
      streak    <= '0;
      i_done    <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Strobes and read data are single-cycle unless set below.
      mem_en  <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      case (state)
        IDLE: begin
          // The mem_* registers double as the request capture; the command
          // cycle is the first BUSY cycle, where lat reads MEM_LAT.
          if (grantD) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            lat       <= LAT_LOAD;
            if (i_req) begin
              streak <= (streak == STREAK_MAX) ? streak : streak + 3'd1;
            end else begin
              streak <= '0;
            end
          end else if (grantI) begin
            state     <= BUSY_I;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            lat       <= LAT_LOAD;
            streak    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (lat == 4'd0) begin
            state <= IDLE;
          end else begin
            lat <= lat - 4'd1;
          end
          // lat==1 is cycle C+MEM_LAT-1: memory data is valid now, and
          // registering it here lands done/rdata in the lat==0 cycle.
          if (lat == 4'd1) begin
            if (state == BUSY_I) begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= mem_wr ? '0 : mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
